// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the multi-cycle data memory (data_memory_mc):
//   - dmem_state_e   : request-handling FSM states (IDLE, WAIT, RESP)
//   - DMEM_DEFAULT_* : default access latency and storage depth
//   - dmem_lanes     : number of byte lanes in a data word
//   - dmem_min1_clog2: ceil(log2(n)) clamped to at least 1 bit
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int DMEM_DEFAULT_LATENCY = 4;
    localparam int DMEM_DEFAULT_DEPTH   = 1024;

    // Byte lanes per word; DATA_WIDTH is a multiple of 8.
    function automatic int dmem_lanes(input int data_width);
        return data_width / 8;
    endfunction

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int dmem_min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH x DATA_WIDTH word storage with a synchronous byte-enabled write port
// and a registered read port. Storage is not reset; only the read register is.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (read register only)
//   i_acc_en    : access strobe; loads the read register
//   i_wr_en     : commit a write this edge (bytes selected by i_be)
//   i_rd_en     : load the read register with the addressed word, else zero
//   i_idx       : word index
//   i_wdata     : write data
//   i_be        : byte enables for writes
//   o_rdata     : registered read data
// -----------------------------------------------------------------------------
module dmem_array import dmem_pkg::*; #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = DMEM_DEFAULT_DEPTH,
    parameter int IDX_W      = dmem_min1_clog2(DEPTH),
    parameter int LANES      = dmem_lanes(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_acc_en,
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    input  logic [IDX_W-1:0]      i_idx,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [LANES-1:0]      i_be,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Byte-lane write into storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < LANES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read register: on every access it carries either the word or zero,
    // so write and error responses present rdata = 0 without extra muxing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_acc_en) begin
            r_rdata <= i_rd_en ? r_mem[i_idx] : '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_mc.sv
// -----------------------------------------------------------------------------
// data_memory_mc
// Multi-cycle data memory for the MEM stage: valid/ready request port, fixed
// access latency, byte-enabled writes and an error response. One request is
// in flight at a time.
// Configuration macro: DMEM_ALIGN_CHK_EN -- when defined, requests with nonzero
// sub-word address bits complete with rsp_err = 1 (no write, rdata = 0);
// when undefined, those bits are ignored and the truncated word is accessed.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid / req_ready : request handshake
//   req_wr, req_addr      : 1 = write / byte address
//   req_wdata, req_be     : write data / byte enables (writes only)
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata, rsp_err    : read data (0 for writes and errors) / rejected
// -----------------------------------------------------------------------------
module data_memory_mc import dmem_pkg::*; #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = DMEM_DEFAULT_DEPTH,
    parameter int LATENCY    = DMEM_DEFAULT_LATENCY
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_wr,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [dmem_lanes(DATA_WIDTH)-1:0] req_be,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err
);

    localparam int LANES  = dmem_lanes(DATA_WIDTH);
    localparam int OFFS_W = $clog2(LANES);
    localparam int IDX_W  = dmem_min1_clog2(DEPTH);
    localparam int CNT_W  = dmem_min1_clog2(LATENCY);

    dmem_state_e           r_state;
    dmem_state_e           w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_latch;

    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [LANES-1:0]      r_be;

    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;

    logic [ADDR_WIDTH-1:0] w_word_idx;
    logic [ADDR_WIDTH:0]   w_depth_lim;
    logic                  w_oor;
    logic                  w_misaligned;
    logic                  w_err;
    logic                  w_access;
    logic                  w_arr_wr_en;
    logic                  w_arr_rd_en;
    logic [DATA_WIDTH-1:0] w_arr_rdata;

    // Decode of the latched request; the live inputs are never used past IDLE.
    assign w_word_idx  = r_addr >> OFFS_W;
    assign w_depth_lim = (ADDR_WIDTH+1)'(DEPTH);
    assign w_oor       = ({1'b0, w_word_idx} >= w_depth_lim);
`ifdef DMEM_ALIGN_CHK_EN
    assign w_misaligned = |r_addr[OFFS_W-1:0];
`else
    assign w_misaligned = 1'b0;
`endif
    assign w_err       = w_oor | w_misaligned;

    // The access edge is the WAIT edge where the counter has run down to 0.
    assign w_access    = (r_state == WAIT) && (r_cnt == CNT_W'(0));
    assign w_arr_wr_en = w_access & r_wr & ~w_err;
    assign w_arr_rd_en = w_access & ~r_wr & ~w_err;

    // Next-state and counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = CNT_W'(LATENCY - 1);
                    w_state_nxt = WAIT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == CNT_W'(0)) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RESP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = CNT_W'(0);
            end
        endcase
    end

    // State, counter and handshake outputs. req_ready/rsp_valid are registered
    // from the next state so both read 0 while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= (w_state_nxt == IDLE);
            r_rsp_valid <= (w_state_nxt == RESP);
        end
    end

    // Request capture at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_latch) begin
            r_wr    <= req_wr;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    // Error flag, captured alongside read data on the access edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_err <= 1'b0;
        end else if (w_access) begin
            r_rsp_err <= w_err;
        end
    end

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W),
        .LANES      (LANES)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_acc_en (w_access),
        .i_wr_en  (w_arr_wr_en),
        .i_rd_en  (w_arr_rd_en),
        .i_idx    (w_word_idx[IDX_W-1:0]),
        .i_wdata  (r_wdata),
        .i_be     (r_be),
        .o_rdata  (w_arr_rdata)
    );

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = w_arr_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_memory_mc.sv
// Directed testbench for data_memory_mc (DATA_WIDTH 16, LATENCY 4, DEPTH 1024).
module tb_data_memory_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rd;
    logic        er;
    int          lat;

    data_memory_mc #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .DEPTH      (1024),
        .LATENCY    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Never both handshakes high in one cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
            check_eq("excl", {31'd0, req_ready}, 32'd0);
        end
    end

    // Full transaction, entered and left on a falling edge; rsp_ready is
    // raised in the first RESP cycle.
    task automatic xact(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [1:0] be, output logic [15:0] o_rd,
                        output logic o_er, output int o_lat);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd; req_be = be;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        o_lat = 0;
        while (rsp_valid !== 1'b1 && o_lat < 50) begin
            @(posedge clk);
            o_lat++;
            @(negedge clk);
        end
        o_rd = rsp_rdata;
        o_er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("b2b_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic check_rst_outputs(input string tag);
        check_eq({tag, "_ready"}, {31'd0, req_ready}, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, rsp_valid}, 32'd0);
        check_eq({tag, "_rdata"}, {16'd0, rsp_rdata}, 32'd0);
        check_eq({tag, "_err"},   {31'd0, rsp_err},   32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = 16'h0000;
        req_wdata = 16'h0000; req_be = 2'b00; rsp_ready = 1'b0;

        // Reset state.
        #2;
        check_rst_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("ready_pre", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check_eq("ready_rise", {31'd0, req_ready}, 32'd1);

        // Write 0xBEEF then read it back.
        xact(1'b1, 16'h0010, 16'hBEEF, 2'b11, rd, er, lat);
        check_eq("w1_err", {31'd0, er}, 32'd0);
        check_eq("w1_rd",  {16'd0, rd}, 32'd0);
        check_eq("w1_lat", lat, 32'd4);
        xact(1'b0, 16'h0010, 16'h0000, 2'b00, rd, er, lat);
        check_eq("r1_rd",  {16'd0, rd}, 32'h0000BEEF);
        check_eq("r1_err", {31'd0, er}, 32'd0);
        check_eq("r1_lat", lat, 32'd4);

        // Partial byte write.
        xact(1'b1, 16'h0020, 16'h1234, 2'b11, rd, er, lat);
        xact(1'b1, 16'h0020, 16'hAB00, 2'b10, rd, er, lat);
        check_eq("w_be_err", {31'd0, er}, 32'd0);
        xact(1'b0, 16'h0020, 16'h0000, 2'b01, rd, er, lat);
        check_eq("be_rd", {16'd0, rd}, 32'h0000AB34);

        // be = 0 write leaves the word alone.
        xact(1'b1, 16'h0020, 16'hFFFF, 2'b00, rd, er, lat);
        check_eq("be0_err", {31'd0, er}, 32'd0);
        xact(1'b0, 16'h0020, 16'h0000, 2'b00, rd, er, lat);
        check_eq("be0_rd", {16'd0, rd}, 32'h0000AB34);

        // Out of range: word index 1024, then the last valid word.
        xact(1'b0, 16'h0800, 16'h0000, 2'b00, rd, er, lat);
        check_eq("oor_err", {31'd0, er}, 32'd1);
        check_eq("oor_rd",  {16'd0, rd}, 32'd0);
        xact(1'b1, 16'h0800, 16'h7777, 2'b11, rd, er, lat);
        check_eq("oor_w_err", {31'd0, er}, 32'd1);
        xact(1'b1, 16'h07FE, 16'h4242, 2'b11, rd, er, lat);
        xact(1'b0, 16'h07FE, 16'h0000, 2'b00, rd, er, lat);
        check_eq("last_rd",  {16'd0, rd}, 32'h00004242);
        check_eq("last_err", {31'd0, er}, 32'd0);
        xact(1'b0, 16'h0000, 16'h0000, 2'b00, rd, er, lat);
        check_eq("wrap_rd", {16'd0, rd}, 32'h00000000 | 32'(rd === 16'h4242 ? 16'hDEAD : rd));
        xact(1'b0, 16'h0010, 16'h0000, 2'b00, rd, er, lat);
        check_eq("after_oor", {16'd0, rd}, 32'h0000BEEF);

        // Response stall with scrambled inputs during WAIT and RESP.
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0020; req_be = 2'b00;
        @(posedge clk);
        @(negedge clk);
        req_wr = 1'b1; req_addr = 16'h0010; req_wdata = 16'h0000; req_be = 2'b11;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq("st_lat", lat, 32'd4);
        for (int i = 0; i < 5; i++) begin
            req_addr  = 16'(16'h0030 + 16'(i));
            req_wdata = 16'(16'h1111 * (i + 1));
            @(negedge clk);
            check_eq("st_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("st_rdata", {16'd0, rsp_rdata}, 32'h0000AB34);
            check_eq("st_err",   {31'd0, rsp_err},   32'd0);
            check_eq("st_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        xact(1'b0, 16'h0010, 16'h0000, 2'b00, rd, er, lat);
        check_eq("st_noclobber", {16'd0, rd}, 32'h0000BEEF);

        // Reset in the middle of WAIT aborts the pending write.
        xact(1'b1, 16'h0030, 16'h0F0F, 2'b11, rd, er, lat);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0030; req_wdata = 16'h5555; req_be = 2'b11;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_rst_outputs("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact(1'b0, 16'h0030, 16'h0000, 2'b00, rd, er, lat);
        check_eq("abort_rd",  {16'd0, rd}, 32'h00000F0F);
        check_eq("abort_err", {31'd0, er}, 32'd0);

        // Misaligned read.
        xact(1'b0, 16'h0011, 16'h0000, 2'b00, rd, er, lat);
`ifdef DMEM_ALIGN_CHK_EN
        check_eq("mis_err", {31'd0, er}, 32'd1);
        check_eq("mis_rd",  {16'd0, rd}, 32'd0);
`else
        check_eq("mis_err", {31'd0, er}, 32'd0);
        check_eq("mis_rd",  {16'd0, rd}, 32'h0000BEEF);
`endif
        check_eq("mis_lat", lat, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
